// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: shared types, latency constants and helpers for the hazard
// scoreboard and its bench.
//   reg_addr_t   architectural register address for the default 32-entry file
//   LAT_*        fixed producer latencies, issue to forwardable
//   sat_inc      saturating increment of a value of width w (w <= 64)
package hazard_pkg;

   localparam int NREGS_DEF = 32;
   localparam int RA_W_DEF  = $clog2(NREGS_DEF);

   typedef logic [RA_W_DEF-1:0] reg_addr_t;

   localparam int LAT_ALU  = 1;
   localparam int LAT_LOAD = 2;
   localparam int LAT_MUL  = 3;

   // Works on a 64-bit carrier so one helper serves any counter width.
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
      logic [63:0] lim;
      lim = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      return (v >= lim) ? lim : v + 64'd1;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage request, writeback and status signals of the
// hazard scoreboard.
//   master  - pipeline side: drives ID/writeback inputs, observes stall/issue
//   slave   - scoreboard side
interface hazard_scoreboard_if #(
   parameter int RA_W   = 5,
   parameter int LAT_W  = 3,
   parameter int PERF_W = 32
);
   logic              id_valid;
   logic [RA_W-1:0]   id_rs1;
   logic [RA_W-1:0]   id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic [RA_W-1:0]   id_rd;
   logic              id_wen;
   logic              id_var;
   logic [LAT_W-1:0]  id_lat;
   logic              flush;
   logic              mem_wait;
   logic              wb_valid;
   logic [RA_W-1:0]   wb_rd;
   logic              stall;
   logic              issue;
   logic [PERF_W-1:0] stall_cycles;
   logic              wb_err;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wen,
             id_var, id_lat, flush, mem_wait, wb_valid, wb_rd,
      input  stall, issue, stall_cycles, wb_err
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wen,
             id_var, id_lat, flush, mem_wait, wb_valid, wb_rd,
      output stall, issue, stall_cycles, wb_err
   );
endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// sb_entry: scoreboard state for one architectural register.
//   clk, rst       pipeline clock, synchronous active-high reset
//   i_set_fixed    load countdown with i_lat_m1 (fixed-latency producer issued)
//   i_lat_m1       cycles remaining until the result is forwardable
//   i_set_var      mark a variable-latency producer pending
//   i_clr_var      its writeback arrived
//   i_dec          pipeline advancing; countdown steps
//   o_busy         register cannot be read/written by ID yet
//   o_vpend        variable-latency write pending
module sb_entry #(
   parameter int LAT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_set_fixed,
   input  logic [LAT_W-1:0] i_lat_m1,
   input  logic             i_set_var,
   input  logic             i_clr_var,
   input  logic             i_dec,
   output logic             o_busy,
   output logic             o_vpend
);
   logic [LAT_W-1:0] r_cnt;
   logic             r_vpend;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_set_fixed) begin
         r_cnt <= i_lat_m1;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - LAT_W'(1);
      end
   end

   // A forced same-cycle set and clear resolves to set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vpend <= 1'b0;
      end else if (i_set_var) begin
         r_vpend <= 1'b1;
      end else if (i_clr_var) begin
         r_vpend <= 1'b0;
      end
   end

   assign o_busy  = (r_cnt != '0) || r_vpend;
   assign o_vpend = r_vpend;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register scoreboard in ID for the RV32 in-order
// pipeline. Stalls ID on RAW/WAW against in-flight fixed-latency producers
// (countdown) and variable-latency producers (pending until writeback).
//   clk, rst   pipeline clock, synchronous active-high reset
//   bus        hazard_scoreboard_if.slave: ID request, writeback, stall/issue,
//              saturating stall-cycle counter, sticky writeback error
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NREGS   = 32,
   parameter int RA_W    = $clog2(NREGS),
   parameter int MAX_LAT = 4,
   parameter int LAT_W   = $clog2(MAX_LAT + 1),
   parameter int MAX_OUT = 2,
   parameter int PERF_W  = 32
) (
   input  logic clk,
   input  logic rst,
   hazard_scoreboard_if.slave bus
);
   // Slots cover the full address space so any rs/rd index is in range;
   // slot 0 and slots >= NREGS are permanently idle.
   localparam int NSLOT = 2 ** RA_W;
   localparam int OUT_W = $clog2(MAX_OUT + 1);

   logic [NSLOT-1:0]  w_busy;
   logic [NSLOT-1:0]  w_vpend;
   logic [LAT_W-1:0]  w_lat_eff;
   logic [LAT_W-1:0]  w_lat_m1;
   logic              w_out_full;
   logic              w_hazard;
   logic              w_stall;
   logic              w_issue;
   logic              w_fix_issue;
   logic              w_var_issue;
   logic              w_wb_act;
   logic              w_wb_hit;
   logic              w_wb_miss;
   logic [OUT_W-1:0]  r_out_cnt;
   logic [PERF_W-1:0] r_stall_cycles;
   logic              r_wb_err;

   always_comb begin
      w_lat_eff = bus.id_lat;
      if (bus.id_lat == '0) begin
         w_lat_eff = LAT_W'(1);
      end else if (bus.id_lat > LAT_W'(MAX_LAT)) begin
         w_lat_eff = LAT_W'(MAX_LAT);
      end
   end
   assign w_lat_m1 = w_lat_eff - LAT_W'(1);

   assign w_out_full = (r_out_cnt == OUT_W'(MAX_OUT));

   // A writeback in the same cycle does not free an outstanding slot here:
   // r_out_cnt is the registered count.
   assign w_hazard = (bus.id_use_rs1 && w_busy[bus.id_rs1])
                  || (bus.id_use_rs2 && w_busy[bus.id_rs2])
                  || (bus.id_wen && w_busy[bus.id_rd])
                  || (bus.id_wen && bus.id_var && w_out_full);

   assign w_stall = bus.id_valid && (w_hazard || bus.mem_wait);
   assign w_issue = bus.id_valid && !w_hazard && !bus.mem_wait && !bus.flush;

   assign w_fix_issue = w_issue && bus.id_wen && !bus.id_var && (bus.id_rd != '0);
   assign w_var_issue = w_issue && bus.id_wen &&  bus.id_var && (bus.id_rd != '0);

   assign w_wb_act  = bus.wb_valid && (bus.wb_rd != '0);
   assign w_wb_hit  = w_wb_act &&  w_vpend[bus.wb_rd];
   assign w_wb_miss = w_wb_act && !w_vpend[bus.wb_rd];

   for (genvar g = 0; g < NSLOT; g++) begin : g_slot
      if ((g == 0) || (g >= NREGS)) begin : g_idle
         assign w_busy[g]  = 1'b0;
         assign w_vpend[g] = 1'b0;
      end else begin : g_ent
         sb_entry #(.LAT_W(LAT_W)) u_ent (
            .clk         (clk),
            .rst         (rst),
            .i_set_fixed (w_fix_issue && (bus.id_rd == RA_W'(g))),
            .i_lat_m1    (w_lat_m1),
            .i_set_var   (w_var_issue && (bus.id_rd == RA_W'(g))),
            .i_clr_var   (w_wb_hit && (bus.wb_rd == RA_W'(g))),
            .i_dec       (!bus.mem_wait),
            .o_busy      (w_busy[g]),
            .o_vpend     (w_vpend[g])
         );
      end
   end

   // Simultaneous issue and writeback-hit cancel out, which also covers a
   // forced set/clear of the same register (set wins in the entry).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_cnt <= '0;
      end else begin
         case ({w_var_issue, w_wb_hit})
            2'b10: if (r_out_cnt != OUT_W'(MAX_OUT)) r_out_cnt <= r_out_cnt + OUT_W'(1);
            2'b01: if (r_out_cnt != '0)              r_out_cnt <= r_out_cnt - OUT_W'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cycles <= '0;
      end else if (w_stall && !bus.flush) begin
         r_stall_cycles <= PERF_W'(sat_inc(64'(r_stall_cycles), PERF_W));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wb_err <= 1'b0;
      end else if (w_wb_miss) begin
         r_wb_err <= 1'b1;
      end
   end

   assign bus.stall        = w_stall;
   assign bus.issue        = w_issue;
   assign bus.stall_cycles = r_stall_cycles;
   assign bus.wb_err       = r_wb_err;
endmodule
